// File: rtl/reg_file_param.sv
// Two-read/one-write register file with configurable width and depth, an optional
// hardwired-zero register, optional write-to-read bypass and a post-reset clear sequencer.
module reg_file_param #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic            we3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy
);

    typedef enum logic {StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;

    // Array has no reset so it can map onto distributed RAM; the clear FSM zeroes it instead.
    logic [XLEN-1:0] mem [NREGS];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            wr_hit;

    assign wr_hit = we3 && !(ZERO_REG && (a3 == '0));
    assign busy   = (state_q == StClear);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = a3;
        mem_wdata = wd3;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: mem_we = wr_hit;
            default: state_d = StClear;
        endcase
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Later assignments take priority: busy over zero-register over bypass over array.
    always_comb begin
        rd1 = mem[a1];
        if (BYPASS && wr_hit && (a3 == a1)) rd1 = wd3;
        if (ZERO_REG && (a1 == '0))         rd1 = '0;
        if (busy)                           rd1 = '0;

        rd2 = mem[a2];
        if (BYPASS && wr_hit && (a3 == a2)) rd2 = wd3;
        if (ZERO_REG && (a2 == '0))         rd2 = '0;
        if (busy)                           rd2 = '0;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default, no-zero/no-bypass and 64x16 instances checked
// against bench-side models through an expected-value queue.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, a3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        busy_0, busy_1;

    logic [3:0]  w_a1, w_a2, w_a3;
    logic        w_we3;
    logic [63:0] w_wd3, w_rd1, w_rd2;
    logic        w_busy;

    always #5 clk = ~clk;

    reg_file_param dut0 (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
        .rd1(rd1_0), .rd2(rd2_0), .busy(busy_0)
    );

    reg_file_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
        .rd1(rd1_1), .rd2(rd2_1), .busy(busy_1)
    );

    reg_file_param #(.XLEN(64), .NREGS(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .a1(w_a1), .a2(w_a2), .a3(w_a3), .we3(w_we3), .wd3(w_wd3),
        .rd1(w_rd1), .rd2(w_rd2), .busy(w_busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [63:0] mw [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        for (int i = 0; i < 16; i++) mw[i] = '0;
    endtask

    task automatic test_reset();
        int fall0, fall2;
        rst_n = 1'b0;
        step();
        step();
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); n_cmp++;
        if ({63'b0, busy_0} !== e) begin n_bad++; $display("FAIL reset busy: got %0d want %0d", busy_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({63'b0, w_busy} !== e) begin n_bad++; $display("FAIL reset wide busy: got %0d want %0d", w_busy, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL reset rd1: got %h want %h", rd1_0, e); end

        // User write attempts to entry 3 during the clear must not land.
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'hAAAA_AAAA;
        rst_n = 1'b1;
        fall0 = 0; fall2 = 0;
        for (int i = 1; i <= 100 && (busy_0 || w_busy); i++) begin
            step();
            if (i == 20) we3 = 1'b0;
            if (!busy_0 && fall0 == 0) fall0 = i;
            if (!w_busy && fall2 == 0) fall2 = i;
        end
        we3 = 1'b0;
        exp_q.push_back(64'd32);
        exp_q.push_back(64'd16);
        e = exp_q.pop_front(); n_cmp++;
        if (fall0 !== int'(e)) begin n_bad++; $display("FAIL clear length: got %0d edges want %0d", fall0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (fall2 !== int'(e)) begin n_bad++; $display("FAIL wide clear length: got %0d edges want %0d", fall2, e); end
        clear_models();

        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            exp_q.push_back({32'b0, m0[a1]});
            exp_q.push_back({32'b0, m0[a2]});
            exp_q.push_back({32'b0, m1[a1]});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL clear rd1 a=%0d: got %h want %h", a1, rd1_0, e); end
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd2_0} !== e) begin n_bad++; $display("FAIL clear rd2 a=%0d: got %h want %h", a2, rd2_0, e); end
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL clear nz rd1 a=%0d: got %h want %h", a1, rd1_1, e); end
        end
        for (int i = 0; i < 16; i++) begin
            w_a1 = 4'(i);
            exp_q.push_back(mw[w_a1]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (w_rd1 !== e) begin n_bad++; $display("FAIL clear wide rd1 a=%0d: got %h want %h", w_a1, w_rd1, e); end
        end
    endtask

    task automatic test_midclear_reset();
        int fall0, fall2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.push_back(64'd1);
        e = exp_q.pop_front(); n_cmp++;
        if ({63'b0, busy_0} !== e) begin n_bad++; $display("FAIL midclear busy: got %0d want %0d", busy_0, e); end
        fall0 = 0; fall2 = 0;
        for (int i = 1; i <= 100 && (busy_0 || w_busy); i++) begin
            step();
            if (!busy_0 && fall0 == 0) fall0 = i;
            if (!w_busy && fall2 == 0) fall2 = i;
        end
        exp_q.push_back(64'd32);
        exp_q.push_back(64'd16);
        e = exp_q.pop_front(); n_cmp++;
        if (fall0 !== int'(e)) begin n_bad++; $display("FAIL midclear length: got %0d edges want %0d", fall0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (fall2 !== int'(e)) begin n_bad++; $display("FAIL midclear wide length: got %0d edges want %0d", fall2, e); end
        clear_models();
    endtask

    task automatic test_basic();
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'h0000_FFFF;
        step();
        m0[1] = 32'h0000_FFFF; m1[1] = 32'h0000_FFFF;
        a3 = 5'd2; wd3 = 32'hFFFF_0000;
        step();
        m0[2] = 32'hFFFF_0000; m1[2] = 32'hFFFF_0000;
        we3 = 1'b0; a1 = 5'd1; a2 = 5'd2;
        exp_q.push_back(64'h0000_FFFF);
        exp_q.push_back(64'hFFFF_0000);
        exp_q.push_back(64'h0000_FFFF);
        exp_q.push_back(64'hFFFF_0000);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL basic rd1: got %h want %h", rd1_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd2_0} !== e) begin n_bad++; $display("FAIL basic rd2: got %h want %h", rd2_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL basic nz rd1: got %h want %h", rd1_1, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd2_1} !== e) begin n_bad++; $display("FAIL basic nz rd2: got %h want %h", rd2_1, e); end
    endtask

    task automatic test_zero_reg();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEAD_BEEF; a1 = 5'd0;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL zero pre rd1: got %h want %h", rd1_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL zero nz pre rd1: got %h want %h", rd1_1, e); end
        step();
        m1[0] = 32'hDEAD_BEEF;
        we3 = 1'b0;
        exp_q.push_back(64'd0);
        exp_q.push_back({32'b0, m1[0]});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL zero post rd1: got %h want %h", rd1_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL zero nz post rd1: got %h want %h", rd1_1, e); end
    endtask

    task automatic test_bypass();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h1111_1111;
        step();
        m0[5] = 32'h1111_1111; m1[5] = 32'h1111_1111;
        wd3 = 32'h2222_2222; a1 = 5'd5; a2 = 5'd5;
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'h1111_1111);
        exp_q.push_back(64'h1111_1111);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL bypass pre rd1: got %h want %h", rd1_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd2_0} !== e) begin n_bad++; $display("FAIL bypass pre rd2: got %h want %h", rd2_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL nobypass pre rd1: got %h want %h", rd1_1, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd2_1} !== e) begin n_bad++; $display("FAIL nobypass pre rd2: got %h want %h", rd2_1, e); end
        step();
        m0[5] = 32'h2222_2222; m1[5] = 32'h2222_2222;
        we3 = 1'b0;
        exp_q.push_back(64'h2222_2222);
        exp_q.push_back(64'h2222_2222);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL bypass post rd1: got %h want %h", rd1_0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({32'b0, rd2_1} !== e) begin n_bad++; $display("FAIL nobypass post rd2: got %h want %h", rd2_1, e); end
    endtask

    task automatic test_wide();
        w_we3 = 1'b1; w_a3 = 4'd15; w_wd3 = 64'hFEDC_BA98_7654_3210; w_a1 = 4'd0; w_a2 = 4'd15;
        exp_q.push_back(64'hFEDC_BA98_7654_3210);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (w_rd2 !== e) begin n_bad++; $display("FAIL wide bypass rd2: got %h want %h", w_rd2, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (w_rd1 !== e) begin n_bad++; $display("FAIL wide zero rd1: got %h want %h", w_rd1, e); end
        step();
        mw[15] = 64'hFEDC_BA98_7654_3210;
        w_a3 = 4'd0; w_wd3 = 64'h0123_4567_89AB_CDEF;
        step();
        w_we3 = 1'b0;
        exp_q.push_back(mw[15]);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (w_rd2 !== e) begin n_bad++; $display("FAIL wide rd2: got %h want %h", w_rd2, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (w_rd1 !== e) begin n_bad++; $display("FAIL wide zero post rd1: got %h want %h", w_rd1, e); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            we3 = 1'($urandom_range(0, 1));
            a3  = 5'($urandom_range(0, 7));
            a1  = 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            wd3 = $urandom();
            exp_q.push_back({32'b0, (a1 == 0) ? 32'd0 : (we3 && a3 != 0 && a3 == a1) ? wd3 : m0[a1]});
            exp_q.push_back({32'b0, (a2 == 0) ? 32'd0 : (we3 && a3 != 0 && a3 == a2) ? wd3 : m0[a2]});
            exp_q.push_back({32'b0, m1[a1]});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd1_0} !== e) begin n_bad++; $display("FAIL random rd1 #%0d: got %h want %h", i, rd1_0, e); end
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd2_0} !== e) begin n_bad++; $display("FAIL random rd2 #%0d: got %h want %h", i, rd2_0, e); end
            e = exp_q.pop_front(); n_cmp++;
            if ({32'b0, rd1_1} !== e) begin n_bad++; $display("FAIL random nz rd1 #%0d: got %h want %h", i, rd1_1, e); end
            step();
            if (we3 && a3 != 0) m0[a3] = wd3;
            if (we3) m1[a3] = wd3;
        end
        we3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        w_we3 = 1'b0; w_a1 = '0; w_a2 = '0; w_a3 = '0; w_wd3 = '0;
        #1;
        test_reset();
        test_midclear_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
